holy_mmio_lite_port: RTL and testbench
======================================

# holy_mmio_lite_port

Non-cacheable AXI-Lite master port that turns single core load/store requests into one AXI-Lite transaction each. It sits downstream of the core's memory stage, beside the data cache, and serves MMIO and uncached address ranges. It produces a `write_back_t` response consumed by the writeback stage. Its FSM uses `cache_state_t` from `holy_core_pkg`; only `IDLE` and the `LITE_*` encodings are legal.

## Interface
- `TIMEOUT_CYCLES`, 256: wait limit per AXI phase. Used only with `MMIO_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: core request valid.
- `req_ready` out 1: request accepted when high together with `req_valid`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `req_funct3` in 3: `load_store_funct3_t` size and signedness.
- `rsp` out 33: `write_back_t`. `data` carries the formatted load result (0 for stores); `valid` is a 1-cycle pulse.
- `rsp_error` out 1: qualifies `rsp.valid`. Set for misalignment, a non-OKAY resp, or a timeout.
- `m_awaddr` out 32, `m_awvalid` out 1, `m_awready` in 1: write address channel.
- `m_wdata` out 32, `m_wstrb` out 4, `m_wvalid` out 1, `m_wready` in 1: write data channel.
- `m_bresp` in 2, `m_bvalid` in 1, `m_bready` out 1: write response channel.
- `m_araddr` out 32, `m_arvalid` out 1, `m_arready` in 1: read address channel.
- `m_rdata` in 32, `m_rresp` in 2, `m_rvalid` in 1, `m_rready` out 1: read data channel.

## Operation
- `req_ready` = (state == `IDLE`). On accept, latch the address, wdata, funct3 and write flag.
- Alignment rules:
  - Word requires `addr[1:0]`==0.
  - Halfword requires `addr[0]`==0.
  - Byte is always aligned.
  - A misaligned request issues no AXI traffic. The next cycle has `rsp.valid`=1, `rsp_error`=1, `data`=0.
- Issued address is always `{addr[31:2],2'b00}`.
- Strobes: byte `4'b0001<<addr[1:0]`; half `4'b0011<<addr[1:0]`; word `4'b1111`.
- `m_wdata` = `req_wdata << (8*addr[1:0])`.
- Write path: `IDLE` → `LITE_SENDING_WRITE_REQ`.
  - Hold `awvalid` until `awready`, then → `LITE_SENDING_WRITE_DATA`.
  - Hold `wvalid` until `wready`, then → `LITE_WAITING_WRITE_RES`.
  - Hold `bready` until `bvalid`, then → `IDLE` with the response pulse.
- Read path: `IDLE` → `LITE_SENDING_READ_REQ`.
  - Hold `arvalid` until `arready`, then → `LITE_RECEIVING_READ_DATA`.
  - Hold `rready` until `rvalid`, then → `IDLE` with the response pulse.
- Load formatting:
  - Select the lane `rdata >> (8*addr[1:0])`.
  - `F3_BYTE`/`F3_HALFWORD` sign-extend; `_U` variants zero-extend; `F3_WORD` passes through.
- `bresp`/`rresp` != 2'b00 → `rsp_error`=1. Load data is forced to 0 in that case.
- `awaddr`/`araddr`/`wdata`/`wstrb` stay stable while the corresponding valid is high.
- Unknown `funct3` is treated as misaligned (error response, no traffic).

## Timing
- Reset values:
  - state `IDLE`, `req_ready`=1.
  - all `m_*valid`/`m_*ready` = 0.
  - `m_awaddr`/`m_araddr`/`m_wdata`=0, `m_wstrb`=0.
  - `rsp`=0, `rsp_error`=0.
- Response is registered. `rsp.valid` is high in the cycle after the final handshake edge, coincident with `IDLE`. A new request may be accepted in that same cycle (back-to-back).
- Minimum latency, accept edge → `rsp.valid` cycle, with the slave always ready:
  - write: 4 cycles
  - read: 3 cycles
  - misaligned: 1 cycle
- Valid/ready signals are registered and assert the cycle after state entry. No combinational path from `m_*ready` to `m_*valid`.
- Slave ready asserted before valid is legal. The handshake completes on the first edge where both are high.
- Reset mid-transaction: all outputs return to reset values immediately (async). No response is produced and the pending request is lost.

## Configuration
- `MMIO_TIMEOUT_EN` defined:
  - A counter clears on each state entry and increments every non-`IDLE` cycle without a handshake.
  - On reaching `TIMEOUT_CYCLES`, valids/readies drop and the FSM goes → `IDLE`. It emits `rsp.valid`=1, `rsp_error`=1, `data`=0.
  - This intentionally violates AXI valid-hold, as hung-slave recovery.
- Not defined: no counter logic. The FSM waits indefinitely and `TIMEOUT_CYCLES` is ignored.

## Test plan
- **SW word:** addr 0x1000_0004, data 0xDEADBEEF, slave always ready → `awaddr` 0x1000_0004, `wstrb` 4'hF, `wdata` 0xDEADBEEF; `rsp.valid` 4 cycles after accept, `rsp_error`=0.
- **LB vs LBU:** addr 0x2000_0003, `rdata` 0x80XX_XXXX → LB `data` 0xFFFF_FF80, LBU `data` 0x0000_0080; `araddr` 0x2000_0000.
- **SH:** addr 0x3000_0002, data 0x0000_1234 → `wstrb` 4'b1100, `wdata` 0x1234_0000. Slave delays `awready` 5 cycles: `awvalid` and `awaddr` held stable throughout.
- **Misaligned LW:** addr 0x4000_0001 → no `arvalid`; next cycle `rsp.valid`=1, `rsp_error`=1, `data`=0.
- **SLVERR:** `rresp`=2'b10 → `rsp_error`=1, `data`=0. Then assert `rst_n` low mid-write (during `LITE_SENDING_WRITE_DATA`) → `wvalid` drops asynchronously, no `rsp.valid`, `req_ready`=1.
- **Timeout:** with `MMIO_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, slave never asserts `arready` → `arvalid` drops and `rsp.valid`/`rsp_error`=1 exactly 16 cycles after `LITE_SENDING_READ_REQ` entry.

Source files
------------

// File: rtl/holy_mmio_lite_port.sv
// Uncached AXI-Lite master: one core load/store becomes one AXI-Lite transaction.
// Optional hung-slave timeout enabled by defining MMIO_TIMEOUT_EN.
package holy_core_pkg;

    typedef enum logic [3:0] {
        IDLE                     = 4'd0,
        SENDING_WRITE_REQ        = 4'd1,
        SENDING_WRITE_DATA       = 4'd2,
        WAITING_WRITE_RES        = 4'd3,
        SENDING_READ_REQ         = 4'd4,
        RECEIVING_READ_DATA      = 4'd5,
        LITE_SENDING_WRITE_REQ   = 4'd6,
        LITE_SENDING_WRITE_DATA  = 4'd7,
        LITE_WAITING_WRITE_RES   = 4'd8,
        LITE_SENDING_READ_REQ    = 4'd9,
        LITE_RECEIVING_READ_DATA = 4'd10
    } cache_state_t;

    typedef enum logic [2:0] {
        F3_BYTE       = 3'b000,
        F3_HALFWORD   = 3'b001,
        F3_WORD       = 3'b010,
        F3_BYTE_U     = 3'b100,
        F3_HALFWORD_U = 3'b101
    } load_store_funct3_t;

    typedef struct packed {
        logic [31:0] data;
        logic        valid;
    } write_back_t;

endpackage

module holy_mmio_lite_port #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic [32:0] rsp,
    output logic        rsp_error,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready
);
    import holy_core_pkg::*;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    cache_state_t state_q;
    write_back_t  rsp_q;
    logic         rsp_err_q;
    logic [1:0]   off_q;
    logic [2:0]   funct3_q;
    logic [31:0]  awaddr_q, araddr_q, wdata_q;
    logic [3:0]   wstrb_q;
    logic         awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;

    logic [1:0]   off;
    logic         req_ok;
    logic [3:0]   req_strb;
    logic         hs;
    logic [31:0]  lane;
    logic [31:0]  ld_data;

    assign off = req_addr[1:0];

    // Unknown funct3 falls through with req_ok=0 and is answered like a misalignment.
    always_comb begin
        req_ok   = 1'b0;
        req_strb = 4'b0000;
        case (req_funct3)
            F3_BYTE, F3_BYTE_U: begin
                req_ok   = 1'b1;
                req_strb = 4'b0001 << off;
            end
            F3_HALFWORD, F3_HALFWORD_U: begin
                req_ok   = ~off[0];
                req_strb = 4'b0011 << off;
            end
            F3_WORD: begin
                req_ok   = (off == 2'b00);
                req_strb = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (state_q)
            LITE_SENDING_WRITE_REQ:   hs = m_awready;
            LITE_SENDING_WRITE_DATA:  hs = m_wready;
            LITE_WAITING_WRITE_RES:   hs = m_bvalid;
            LITE_SENDING_READ_REQ:    hs = m_arready;
            LITE_RECEIVING_READ_DATA: hs = m_rvalid;
            default:                  hs = 1'b0;
        endcase
    end

    assign lane = m_rdata >> {off_q, 3'b000};

    always_comb begin
        case (funct3_q)
            F3_BYTE:       ld_data = {{24{lane[7]}}, lane[7:0]};
            F3_BYTE_U:     ld_data = {24'd0, lane[7:0]};
            F3_HALFWORD:   ld_data = {{16{lane[15]}}, lane[15:0]};
            F3_HALFWORD_U: ld_data = {16'd0, lane[15:0]};
            default:       ld_data = lane;
        endcase
    end

`ifdef MMIO_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rsp_q     <= '0;
            rsp_err_q <= 1'b0;
            off_q     <= 2'b00;
            funct3_q  <= 3'b000;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
`ifdef MMIO_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            rsp_q     <= '0;
            rsp_err_q <= 1'b0;
`ifdef MMIO_TIMEOUT_EN
            tmo_cnt_q <= (state_q == IDLE || hs) ? '0 : tmo_cnt_q + 1'b1;
`endif
            case (state_q)
                IDLE: if (req_valid) begin
                    off_q    <= off;
                    funct3_q <= req_funct3;
                    if (!req_ok) begin
                        rsp_q.valid <= 1'b1;
                        rsp_err_q   <= 1'b1;
                    end else if (req_write) begin
                        state_q   <= LITE_SENDING_WRITE_REQ;
                        awaddr_q  <= {req_addr[31:2], 2'b00};
                        wdata_q   <= req_wdata << {off, 3'b000};
                        wstrb_q   <= req_strb;
                        awvalid_q <= 1'b1;
                    end else begin
                        state_q   <= LITE_SENDING_READ_REQ;
                        araddr_q  <= {req_addr[31:2], 2'b00};
                        arvalid_q <= 1'b1;
                    end
                end
                LITE_SENDING_WRITE_REQ: if (hs) begin
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b1;
                    state_q   <= LITE_SENDING_WRITE_DATA;
                end
                LITE_SENDING_WRITE_DATA: if (hs) begin
                    wvalid_q <= 1'b0;
                    bready_q <= 1'b1;
                    state_q  <= LITE_WAITING_WRITE_RES;
                end
                LITE_WAITING_WRITE_RES: if (hs) begin
                    bready_q    <= 1'b0;
                    state_q     <= IDLE;
                    rsp_q.valid <= 1'b1;
                    rsp_err_q   <= |m_bresp;
                end
                LITE_SENDING_READ_REQ: if (hs) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state_q   <= LITE_RECEIVING_READ_DATA;
                end
                LITE_RECEIVING_READ_DATA: if (hs) begin
                    rready_q    <= 1'b0;
                    state_q     <= IDLE;
                    rsp_q.valid <= 1'b1;
                    rsp_q.data  <= (|m_rresp) ? 32'd0 : ld_data;
                    rsp_err_q   <= |m_rresp;
                end
                default: state_q <= IDLE;
            endcase
`ifdef MMIO_TIMEOUT_EN
            // Hung-slave recovery: abandon the phase even though AXI wants valid held.
            if (state_q != IDLE && !hs && tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                awvalid_q   <= 1'b0;
                wvalid_q    <= 1'b0;
                bready_q    <= 1'b0;
                arvalid_q   <= 1'b0;
                rready_q    <= 1'b0;
                state_q     <= IDLE;
                rsp_q       <= '0;
                rsp_q.valid <= 1'b1;
                rsp_err_q   <= 1'b1;
            end
`endif
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp       = rsp_q;
    assign rsp_error = rsp_err_q;
    assign m_awaddr  = awaddr_q;
    assign m_awvalid = awvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign m_araddr  = araddr_q;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;

endmodule

// File: tb/tb_holy_mmio_lite_port.sv
// Directed bench for holy_mmio_lite_port; slave side is driven by the stimulus itself.
module tb_holy_mmio_lite_port;
    import holy_core_pkg::*;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic [32:0] rsp;
    logic        rsp_error;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    write_back_t wb;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_acc   = 0;
    int lat;

    holy_mmio_lite_port #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp(rsp), .rsp_error(rsp_error),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    assign wb = rsp;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] chans();
        return {27'd0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready};
    endfunction

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f3);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = a;
        req_wdata  = d;
        req_funct3 = f3;
        chk("req_ready_at_accept", 32'(req_ready), 32'd1);
        t_acc = cyc;
        tick();
        req_valid = 1'b0;
    endtask

    // Latency is counted from the accept cycle to the rsp.valid cycle; -1 if none came.
    task automatic wait_rsp(input int maxc, output int l);
        int g = 0;
        while (!wb.valid && g < maxc) begin
            tick();
            g++;
        end
        l = wb.valid ? (cyc - t_acc) : -1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; req_funct3 = '0;
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b00;
        m_arready = 1'b1; m_rvalid = 1'b1; m_rresp = 2'b00; m_rdata = 32'h8012_3456;
        tick(); tick();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_chans", chans(), 32'd0);
        chk("rst_awaddr", m_awaddr, 32'd0);
        chk("rst_araddr", m_araddr, 32'd0);
        chk("rst_wdata", m_wdata, 32'd0);
        chk("rst_wstrb", 32'(m_wstrb), 32'd0);
        chk("rst_rsp", {rsp[31:0]} | 32'(rsp[32]), 32'd0);
        chk("rst_rsp_error", 32'(rsp_error), 32'd0);
        rst_n = 1'b1;
        tick();

        // SW word, slave always ready
        issue(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 3'b010);
        chk("sw_awvalid", 32'(m_awvalid), 32'd1);
        chk("sw_awaddr", m_awaddr, 32'h1000_0004);
        chk("sw_wstrb", 32'(m_wstrb), 32'hF);
        chk("sw_wdata", m_wdata, 32'hDEAD_BEEF);
        wait_rsp(20, lat);
        chk("sw_latency", lat, 32'd4);
        chk("sw_err", 32'(rsp_error), 32'd0);
        chk("sw_data", wb.data, 32'd0);
        chk("sw_rsp_idle", 32'(req_ready), 32'd1);

        // LB / LBU at byte lane 3 (back-to-back from the rsp cycle)
        issue(1'b0, 32'h2000_0003, 32'd0, 3'b000);
        chk("lb_arvalid", 32'(m_arvalid), 32'd1);
        chk("lb_araddr", m_araddr, 32'h2000_0000);
        wait_rsp(20, lat);
        chk("lb_latency", lat, 32'd3);
        chk("lb_data", wb.data, 32'hFFFF_FF80);
        chk("lb_err", 32'(rsp_error), 32'd0);
        issue(1'b0, 32'h2000_0003, 32'd0, 3'b100);
        wait_rsp(20, lat);
        chk("lbu_data", wb.data, 32'h0000_0080);
        issue(1'b0, 32'h2000_0002, 32'd0, 3'b001);
        wait_rsp(20, lat);
        chk("lh_data", wb.data, 32'hFFFF_8012);
        issue(1'b0, 32'h2000_0002, 32'd0, 3'b101);
        wait_rsp(20, lat);
        chk("lhu_data", wb.data, 32'h0000_8012);
        issue(1'b0, 32'h2000_0008, 32'd0, 3'b010);
        wait_rsp(20, lat);
        chk("lw_data", wb.data, 32'h8012_3456);

        // SH at offset 2 with awready held off for 5 cycles
        tick();
        m_awready = 1'b0;
        issue(1'b1, 32'h3000_0002, 32'h0000_1234, 3'b001);
        chk("sh_wstrb", 32'(m_wstrb), 32'hC);
        chk("sh_wdata", m_wdata, 32'h1234_0000);
        for (int i = 0; i < 5; i++) begin
            chk("sh_awvalid_hold", 32'(m_awvalid), 32'd1);
            chk("sh_awaddr_hold", m_awaddr, 32'h3000_0000);
            chk("sh_wvalid_low", 32'(m_wvalid), 32'd0);
            tick();
        end
        m_awready = 1'b1;
        wait_rsp(20, lat);
        chk("sh_latency", lat, 32'd9);
        chk("sh_err", 32'(rsp_error), 32'd0);

        // SB at offset 1 with SLVERR-like bresp
        tick();
        m_bresp = 2'b11;
        issue(1'b1, 32'h5000_0001, 32'h0000_00AB, 3'b000);
        chk("sb_wstrb", 32'(m_wstrb), 32'h2);
        chk("sb_wdata", m_wdata, 32'h0000_AB00);
        chk("sb_awaddr", m_awaddr, 32'h5000_0000);
        wait_rsp(20, lat);
        chk("sb_bresp_err", 32'(rsp_error), 32'd1);
        m_bresp = 2'b00;

        // Misaligned LW and unknown funct3: no traffic, error next cycle
        tick();
        issue(1'b0, 32'h4000_0001, 32'd0, 3'b010);
        chk("mis_chans", chans(), 32'd0);
        chk("mis_valid", 32'(wb.valid), 32'd1);
        chk("mis_err", 32'(rsp_error), 32'd1);
        chk("mis_data", wb.data, 32'd0);
        tick();
        chk("mis_pulse_end", 32'(wb.valid), 32'd0);
        chk("mis_chans2", chans(), 32'd0);
        issue(1'b1, 32'h4000_0003, 32'h1, 3'b001);
        chk("mis_sh_chans", chans(), 32'd0);
        chk("mis_sh_err", {31'd0, rsp_error} & 32'(wb.valid), 32'd1);
        tick();
        issue(1'b0, 32'h4000_0000, 32'd0, 3'b011);
        chk("bad_f3_chans", chans(), 32'd0);
        chk("bad_f3_err", {31'd0, rsp_error} & 32'(wb.valid), 32'd1);
        tick();

        // SLVERR on read: data forced to 0
        m_rresp = 2'b10;
        issue(1'b0, 32'h6000_0000, 32'd0, 3'b010);
        wait_rsp(20, lat);
        chk("rd_slverr_err", 32'(rsp_error), 32'd1);
        chk("rd_slverr_data", wb.data, 32'd0);
        m_rresp = 2'b00;
        tick();

        // Async reset in the middle of the write data phase
        m_wready = 1'b0;
        issue(1'b1, 32'h7000_0000, 32'h55AA_55AA, 3'b010);
        tick();
        chk("rstmid_wvalid_before", 32'(m_wvalid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_wvalid_async", 32'(m_wvalid), 32'd0);
        chk("rstmid_req_ready", 32'(req_ready), 32'd1);
        m_wready = 1'b1;
        tick();
        chk("rstmid_no_rsp", 32'(wb.valid), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("rstmid_no_rsp_after", 32'(wb.valid), 32'd0);
        chk("rstmid_chans_after", chans(), 32'd0);

`ifdef MMIO_TIMEOUT_EN
        // Slave never accepts the read address: recovery after 16 cycles in the phase
        m_arready = 1'b0;
        issue(1'b0, 32'h8000_0000, 32'd0, 3'b010);
        wait_rsp(40, lat);
        chk("tmo_cycles_from_entry", lat - 1, 32'd16);
        chk("tmo_err", 32'(rsp_error), 32'd1);
        chk("tmo_data", wb.data, 32'd0);
        chk("tmo_arvalid_drop", 32'(m_arvalid), 32'd0);
        chk("tmo_idle", 32'(req_ready), 32'd1);
        m_arready = 1'b1;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
